// File: rtl/note_ctrl.sv
// Note controller: parses note-on/off bytes from the UART receiver, keeps a
// 24-key held mask and publishes the highest held key, velocity and light selector.
module note_ctrl #(
  parameter int C_CHANNEL   = 0,
  parameter int C_BASE_NOTE = 60
) (
  input  logic        clk,
  input  logic        rstb,
  input  logic        rxValid,
  input  logic [7:0]  rxData,
  input  logic        rxErr,
  output logic        rxAck,
  output logic [23:0] keyMask,
  output logic        noteOn,
  output logic [4:0]  note,
  output logic [6:0]  velocity,
  output logic [7:0]  ctrlLight,
  output logic [7:0]  errCount,
  output logic [1:0]  dbgState
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_NOTE = 2'd1, S_VEL = 2'd2} state_t;
  typedef enum logic [1:0] {RS_NONE = 2'd0, RS_ON = 2'd1, RS_OFF = 2'd2} run_t;

  localparam logic [7:0] ST_OFF  = 8'h80 | {4'h0, 4'(C_CHANNEL)};
  localparam logic [7:0] ST_ON   = 8'h90 | {4'h0, 4'(C_CHANNEL)};
  localparam logic [7:0] BASE8   = 8'(C_BASE_NOTE);

  state_t     state, stateNext;
  run_t       runSt, runNext;
  logic [6:0] noteReg;
  logic [6:0] velReg;
  logic [4:0] hiKey;
  logic [7:0] keyIdx;
  logic       accept, loadNote, complete, countErr, inRange, setKey;

  // Handshake: a byte is taken on an edge with rxValid=1 and rxAck=0; rxAck is
  // high for exactly the next cycle, so a rxValid held through the ack cycle is
  // never taken twice.
  assign accept   = rxValid & ~rxAck;
  assign dbgState = state;

  assign keyIdx  = {1'b0, noteReg} - BASE8;
  assign inRange = ~keyIdx[7] && (keyIdx <= 8'd23);
  assign setKey  = (runSt == RS_ON) && (rxData[6:0] != 7'd0);

  always_ff @(posedge clk) begin
    if (!rstb) begin
      state <= S_IDLE;
      runSt <= RS_NONE;
    end else begin
      state <= stateNext;
      runSt <= runNext;
    end
  end

  always_comb begin
    stateNext = state;
    runNext   = runSt;
    if (accept) begin
      if (rxErr) begin
        stateNext = S_IDLE;
        runNext   = RS_NONE;
      end else if (rxData[7]) begin
        if (rxData == ST_OFF) begin
          runNext   = RS_OFF;
          stateNext = S_NOTE;
        end else if (rxData == ST_ON) begin
          runNext   = RS_ON;
          stateNext = S_NOTE;
        end else begin
          runNext   = RS_NONE;
          stateNext = S_IDLE;
        end
      end else begin
        case (state)
          S_IDLE:  if (runSt != RS_NONE) stateNext = S_VEL;
          S_NOTE:  stateNext = S_VEL;
          S_VEL:   stateNext = S_IDLE;
          default: stateNext = S_IDLE;
        endcase
      end
    end
  end

  always_comb begin
    loadNote = 1'b0;
    complete = 1'b0;
    countErr = 1'b0;
    if (accept) begin
      if (rxErr) begin
        countErr = 1'b1;
      end else if (!rxData[7]) begin
        loadNote = (state == S_NOTE) || ((state == S_IDLE) && (runSt != RS_NONE));
        complete = (state == S_VEL);
      end
    end
  end

  // Highest held key wins: later (higher) indices overwrite lower ones.
  always_comb begin
    hiKey = 5'd0;
    for (int i = 0; i < 24; i++) begin
      if (keyMask[i]) hiKey = 5'(i);
    end
  end

  always_ff @(posedge clk) begin
    if (!rstb) begin
      rxAck     <= 1'b0;
      noteReg   <= 7'd0;
      velReg    <= 7'd0;
      keyMask   <= 24'd0;
      errCount  <= 8'd0;
      noteOn    <= 1'b0;
      note      <= 5'd0;
      velocity  <= 7'd0;
      ctrlLight <= 8'd0;
    end else begin
      rxAck <= accept;
      if (loadNote) noteReg <= rxData[6:0];
      if (complete && inRange) begin
        if (setKey) begin
          keyMask[keyIdx[4:0]] <= 1'b1;
          velReg               <= rxData[6:0];
        end else begin
          keyMask[keyIdx[4:0]] <= 1'b0;
        end
      end
      if (countErr && (errCount != 8'hFF)) errCount <= errCount + 8'd1;
      // Publish stage trails the mask by one cycle so all visible outputs are registered.
      noteOn    <= |keyMask;
      note      <= hiKey;
      velocity  <= velReg;
      ctrlLight <= {|keyMask, velReg[6:5], hiKey};
    end
  end

endmodule
